// File: rtl/serial_pe_pkg.sv
// Shared widths and FSM state encoding for the serial PE datapath and its feeder.
package serial_pe_pkg;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int LEN_W  = 10;
    localparam int NUM_W  = 8;
    localparam int NRN_AW = 10;
    localparam int WGT_AW = 18;
    localparam int OUT_AW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;
endpackage

// File: rtl/serial_pe.sv
// Serial signed MAC: one beat per cycle, result registered 1 cycle after the last beat.
// No backpressure: every valid beat is consumed.
module serial_pe
    import serial_pe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pe_neuron,
    input  logic [DATA_W-1:0] pe_weight,
    input  logic [1:0]        pe_ctl,
    input  logic              pe_vld,
    output logic [ACC_W-1:0]  pe_result,
    output logic              pe_vld_o
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] n_ext;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] sum;

    // Sign-extend to the accumulator width; the low 32 bits of the product are exact.
    assign n_ext = {{(ACC_W-DATA_W){pe_neuron[DATA_W-1]}}, pe_neuron};
    assign w_ext = {{(ACC_W-DATA_W){pe_weight[DATA_W-1]}}, pe_weight};
    assign prod  = n_ext * w_ext;
    assign sum   = pe_ctl[0] ? prod : acc + prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            pe_result <= '0;
            pe_vld_o  <= 1'b0;
        end else begin
            pe_vld_o <= 1'b0;
            if (pe_vld) begin
                acc <= sum;
                if (pe_ctl[1]) begin
                    pe_result <= sum;
                    pe_vld_o  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pe_feeder.sv
// Streams neuron/weight beats to serial_pe and writes each result; job latency num_out*(len+2)+1.
// No backpressure: stalls only in DRAIN waiting for pe_vld_o.
module pe_feeder
    import serial_pe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [NUM_W-1:0]  cfg_num_out,
    output logic              rd_en,
    output logic [NRN_AW-1:0] nrn_addr,
    output logic [WGT_AW-1:0] wgt_addr,
    input  logic [DATA_W-1:0] nrn_rdata,
    input  logic [DATA_W-1:0] wgt_rdata,
    output logic [DATA_W-1:0] pe_neuron,
    output logic [DATA_W-1:0] pe_weight,
    output logic [1:0]        pe_ctl,
    output logic              pe_vld,
    input  logic [ACC_W-1:0]  pe_result,
    input  logic              pe_vld_o,
    output logic              out_wr_en,
    output logic [OUT_AW-1:0] out_addr,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy,
    output logic              done
);
    fsm_state_t       state;
    logic [LEN_W-1:0] len_q;
    logic [NUM_W-1:0] num_q;
    logic [NUM_W-1:0] out_idx;
    logic             last_beat;
    logic             last_out;
    logic             in_drain;

    // nrn_addr doubles as the beat index i within the current output.
    assign last_beat = (nrn_addr == len_q - LEN_W'(1));
    assign last_out  = (out_idx == num_q - NUM_W'(1));
    assign in_drain  = (state == ST_DRAIN);

    assign pe_neuron = nrn_rdata;
    assign pe_weight = wgt_rdata;
    assign out_wr_en = in_drain & pe_vld_o;
    assign out_addr  = in_drain ? out_idx : '0;
    assign out_data  = in_drain ? pe_result : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            num_q    <= '0;
            out_idx  <= '0;
            rd_en    <= 1'b0;
            nrn_addr <= '0;
            wgt_addr <= '0;
            pe_ctl   <= 2'b00;
            pe_vld   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_len != '0 && cfg_num_out != '0) begin
                            len_q    <= cfg_len;
                            num_q    <= cfg_num_out;
                            out_idx  <= '0;
                            nrn_addr <= '0;
                            wgt_addr <= '0;
                            rd_en    <= 1'b1;
                            busy     <= 1'b1;
                            state    <= ST_ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    pe_vld   <= 1'b1;
                    pe_ctl   <= {last_beat, nrn_addr == '0};
                    // Weight pointer runs across outputs, so it is o*len+i without a multiply.
                    wgt_addr <= wgt_addr + WGT_AW'(1);
                    if (last_beat) begin
                        rd_en <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        nrn_addr <= nrn_addr + NRN_AW'(1);
                    end
                end
                ST_DRAIN: begin
                    pe_vld <= 1'b0;
                    pe_ctl <= 2'b00;
                    if (pe_vld_o) begin
                        if (last_out) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            out_idx  <= out_idx + NUM_W'(1);
                            nrn_addr <= '0;
                            rd_en    <= 1'b1;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder with serial_pe and 1-cycle-latency RAM models; scoreboard-checked.
module tb_pe_feeder;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  cfg_len;
    logic [7:0]  cfg_num_out;
    logic        rd_en;
    logic [9:0]  nrn_addr;
    logic [17:0] wgt_addr;
    logic [15:0] nrn_rdata;
    logic [15:0] wgt_rdata;
    logic [15:0] pe_neuron;
    logic [15:0] pe_weight;
    logic [1:0]  pe_ctl;
    logic        pe_vld;
    logic [31:0] pe_result;
    logic        pe_vld_o;
    logic        out_wr_en;
    logic [7:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic [15:0] nrn_mem [16];
    logic [15:0] wgt_mem [16];

    logic [27:0] exp_rd  [$];
    logic [1:0]  exp_ctl [$];
    logic [39:0] exp_wr  [$];

    int errors = 0;
    int checks = 0;

    pe_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_num_out(cfg_num_out),
        .rd_en(rd_en), .nrn_addr(nrn_addr), .wgt_addr(wgt_addr),
        .nrn_rdata(nrn_rdata), .wgt_rdata(wgt_rdata),
        .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_ctl(pe_ctl), .pe_vld(pe_vld),
        .pe_result(pe_result), .pe_vld_o(pe_vld_o),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    serial_pe pe (
        .clk(clk), .rst_n(rst_n), .pe_neuron(pe_neuron), .pe_weight(pe_weight),
        .pe_ctl(pe_ctl), .pe_vld(pe_vld), .pe_result(pe_result), .pe_vld_o(pe_vld_o)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrn_rdata <= '0;
            wgt_rdata <= '0;
        end else if (rd_en) begin
            nrn_rdata <= nrn_mem[nrn_addr[3:0]];
            wgt_rdata <= wgt_mem[wgt_addr[3:0]];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every read, beat and write must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                if (exp_rd.size() == 0) check("rd_unexpected", {nrn_addr, wgt_addr}, 64'hDEAD);
                else check("rd_addr", {nrn_addr, wgt_addr}, exp_rd.pop_front());
            end
            if (pe_vld) begin
                if (exp_ctl.size() == 0) check("ctl_unexpected", pe_ctl, 64'hDEAD);
                else check("pe_ctl", pe_ctl, exp_ctl.pop_front());
            end
            if (out_wr_en) begin
                if (exp_wr.size() == 0) check("wr_unexpected", {out_addr, out_data}, 64'hDEAD);
                else check("wr", {out_addr, out_data}, exp_wr.pop_front());
            end
        end
    end

    task automatic push_beats(input int len, input int num);
        for (int o = 0; o < num; o++) begin
            for (int i = 0; i < len; i++) begin
                exp_rd.push_back({10'(i), 18'(o * len + i)});
                exp_ctl.push_back({(i == len - 1), (i == 0)});
            end
        end
    endtask

    task automatic run_job(input string name, input int len, input int num,
                           input int exp_lat, input bit poke);
        int  n;
        bit  seen;
        @(negedge clk);
        cfg_len     = 10'(len);
        cfg_num_out = 8'(num);
        start       = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start       = 1'b0;
                cfg_len     = 10'd7;
                cfg_num_out = 8'd9;
            end
            if (poke && n == 3) begin
                start       = 1'b1;
                cfg_len     = 10'd1;
                cfg_num_out = 8'd3;
            end
            if (poke && n == 4) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        @(negedge clk);
        check({name, "_done_pulse"}, {busy, done}, 2'b00);
        check({name, "_queues_empty"}, 64'(exp_rd.size() + exp_ctl.size() + exp_wr.size()), 0);
    endtask

    task automatic load_j3();
        nrn_mem[0] = 16'd1;  nrn_mem[1] = 16'd2;  nrn_mem[2] = 16'd3;
        wgt_mem[0] = 16'd2;  wgt_mem[1] = -16'sd1; wgt_mem[2] = 16'd3;
        wgt_mem[3] = 16'd10; wgt_mem[4] = 16'd20;  wgt_mem[5] = 16'd30;
        push_beats(3, 2);
        exp_wr.push_back({8'd0, 32'd9});
        exp_wr.push_back({8'd1, 32'd140});
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        cfg_len     = '0;
        cfg_num_out = '0;
        for (int k = 0; k < 16; k++) begin
            nrn_mem[k] = '0;
            wgt_mem[k] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {rd_en, nrn_addr, wgt_addr, pe_neuron, pe_weight, pe_ctl, pe_vld},
              64'd0);
        check("reset_out_port", {out_wr_en, out_addr, out_data, busy, done}, 64'd0);
        rst_n = 1'b1;

        // Dot product 1*5+2*6+3*7+4*8.
        nrn_mem[0] = 16'd1; nrn_mem[1] = 16'd2; nrn_mem[2] = 16'd3; nrn_mem[3] = 16'd4;
        wgt_mem[0] = 16'd5; wgt_mem[1] = 16'd6; wgt_mem[2] = 16'd7; wgt_mem[3] = 16'd8;
        push_beats(4, 1);
        exp_wr.push_back({8'd0, 32'd70});
        run_job("j1", 4, 1, 7, 1'b0);

        // Single-beat outputs: -2*3, -2*-4, -2*5.
        nrn_mem[0] = -16'sd2;
        wgt_mem[0] = 16'd3; wgt_mem[1] = -16'sd4; wgt_mem[2] = 16'd5;
        push_beats(1, 3);
        exp_wr.push_back({8'd0, 32'hFFFF_FFFA});
        exp_wr.push_back({8'd1, 32'd8});
        exp_wr.push_back({8'd2, 32'hFFFF_FFF6});
        run_job("j2", 1, 3, 10, 1'b0);

        load_j3();
        run_job("j3", 3, 2, 11, 1'b0);

        // (-32768)^2 * 2 = 2^31 wraps into the sign bit.
        nrn_mem[0] = 16'h8000; nrn_mem[1] = 16'h8000;
        wgt_mem[0] = 16'h8000; wgt_mem[1] = 16'h8000;
        push_beats(2, 1);
        exp_wr.push_back({8'd0, 32'h8000_0000});
        run_job("j4_wrap", 2, 1, 5, 1'b0);

        run_job("zero_len", 0, 5, 1, 1'b0);
        run_job("zero_num", 3, 0, 1, 1'b0);

        // Start pulsed mid-job with different config must not disturb the job.
        nrn_mem[0] = 16'd1; nrn_mem[1] = 16'd2; nrn_mem[2] = 16'd3; nrn_mem[3] = 16'd4;
        wgt_mem[0] = 16'd5; wgt_mem[1] = 16'd6; wgt_mem[2] = 16'd7; wgt_mem[3] = 16'd8;
        push_beats(4, 1);
        exp_wr.push_back({8'd0, 32'd70});
        run_job("busy_poke", 4, 1, 7, 1'b1);

        // Abort during ISSUE of output 1 (first beat of output 1 is six negedges after start).
        load_j3();
        @(negedge clk);
        cfg_len     = 10'd3;
        cfg_num_out = 8'd2;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              {rd_en, nrn_addr, wgt_addr, pe_neuron, pe_weight, pe_ctl, pe_vld},
              64'd0);
        check("abort_out_port", {out_wr_en, out_addr, out_data, busy, done}, 64'd0);
        exp_rd.delete();
        exp_ctl.delete();
        exp_wr.delete();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        begin
            bit saw_done;
            saw_done = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (done || busy) saw_done = 1'b1;
            end
            check("abort_no_done", 64'(saw_done), 64'd0);
        end

        load_j3();
        run_job("after_abort", 3, 2, 11, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
